gf180mcu_aoi_array_pipe: RTL
============================

Name: gf180mcu_aoi_array_pipe

Overview:
Parametrised, pipelined successor to the fixed 2-2-2 AND-OR-INVERT cell. It evaluates LANES independent AND-OR(-INVERT) reductions, each with GROUPS terms of TERM_W inputs. The function is selectable at run time: AOI, OAI, AO or OA. It sits between datapath registers behind a valid/ready handshake, for characterisation harnesses and wide control-decode logic.

Parameters:
LANES, 4, number of independent output lanes
GROUPS, 3, product/sum terms per lane (>=1)
TERM_W, 2, inputs per term (>=1)
CNT_W, 16, toggle-counter width (used only with the optional feature)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
VDD  inout  1  supply pin, no functional use
VSS  inout  1  ground pin, no functional use
IN_VALID  input  1  IN_DATA/MODE valid
IN_READY  output  1  block accepts this cycle
IN_DATA  input  LANES*GROUPS*TERM_W  lane l, group g, input t at bit (l*GROUPS+g)*TERM_W+t
MODE  input  2  00 AOI, 01 OAI, 10 AO, 11 OA; sampled with IN_DATA
OUT_VALID  output  1  ZN valid
OUT_READY  input  1  downstream accepts
ZN  output  LANES  lane results
CNT_CLR  input  1  synchronous clear of toggle counters
TOGGLE_CNT  output  LANES*CNT_W  per-lane ZN toggle counts

Behaviour:
- Reset (async assert, sync use after release): s1_valid=0, s2_valid=0, OUT_VALID=0, ZN=all 1s, TOGGLE_CNT=0. Data registers are reset to 0.
- Stage 1 registers IN_DATA and MODE on accept (IN_VALID && IN_READY).
- Stage 2 registers the computed lane function and MODE-independent valid.
- Lane function:
  - AO: OR over g of (AND over t).
  - AOI: NOT AO.
  - OA: AND over g of (OR over t).
  - OAI: NOT OA.
- Latency: accept at edge N -> OUT_VALID=1 with the result after edge N+1 (two registers, one bubble-free stage boundary).
- Throughput: 1 item per cycle while OUT_READY=1.
- Stall: s2 holds when OUT_VALID && !OUT_READY. s1 advances into s2 only when s2 is empty or draining.
- IN_READY = !s1_valid || !s2_valid || OUT_READY. This is combinational from OUT_READY; no other comb path exists.
- ZN and OUT_VALID are stable while OUT_VALID && !OUT_READY; no data is dropped or duplicated.
- Simultaneous accept and drain in the same cycle is allowed; full throughput is maintained.
- Bubbles collapse: an empty s2 is filled even if OUT_READY=0.
- Reset mid-transfer discards all in-flight items; the first post-reset accept behaves as from idle.
- X/Z on IN_DATA follows 4-state operator semantics; no masking.

Optional Feature:
- Macro GF180MCU_AOI_TOGGLE_CNT_EN.
- Defined:
  - Per-lane saturating CNT_W counter increments when an item leaves s2 (OUT_VALID && OUT_READY) and its ZN[l] differs from the previously delivered ZN[l]. The first delivery after reset compares against the reset value (all 1s).
  - Counters saturate at all-ones.
  - CNT_CLR zeros all counters; CNT_CLR takes priority over an increment in the same cycle.
- Undefined: TOGGLE_CNT tied to 0, CNT_CLR ignored, no counter flops.

Decomposition:
- Package gf180mcu_aoi_pkg: MODE enum (AOI, OAI, AO, OA), mode encodings, bit-index helper function for (lane, group, term).
- One sub-module, gf180mcu_aoi_lane: purely combinational single-lane evaluator (GROUPS, TERM_W, mode), instantiated LANES times in a generate loop. Pipeline and counter logic stay in the top.

Test Plan:
- Defaults. MODE=AOI, lane0 IN_DATA[5:0]=6'b000011 (A=11), other lanes 0, OUT_READY=1 -> two cycles later OUT_VALID=1, ZN=4'b1110.
- MODE=OAI, lane0 A=01, B=10, C=01 -> ZN[0]=0. Same data with MODE=OA -> ZN[0]=1. All-zero lane under OA -> 0.
- Back-to-back: 8 items, OUT_READY=1 -> 8 consecutive OUT_VALID cycles, results in order, IN_READY never low.
- Backpressure: OUT_READY=0 for 5 cycles with 3 offered items -> IN_READY drops after 2 accepts, ZN held stable. On release, all 3 emerge in order.
- Assert RST with 2 items in flight -> OUT_VALID=0 and ZN=all 1s immediately (asynchronous). No stale item appears after release.
- With GF180MCU_AOI_TOGGLE_CNT_EN defined, deliver ZN[0] sequence 1,0,1,1,0 -> TOGGLE_CNT lane0=3. Then pulse CNT_CLR -> 0. Force count to 16'hFFFF and toggle -> stays 16'hFFFF.

Source files
------------

// File: rtl/gf180mcu_aoi_pkg.sv
// Shared types and helpers for the gf180mcu AND-OR(-INVERT) lane array.
// Mode encoding matches the MODE input: 00 AOI, 01 OAI, 10 AO, 11 OA.
package gf180mcu_aoi_pkg;

  typedef enum logic [1:0] {
    MODE_AOI = 2'b00,
    MODE_OAI = 2'b01,
    MODE_AO  = 2'b10,
    MODE_OA  = 2'b11
  } mode_e;

  // Flat bit position of (lane, group, term) inside the packed input word.
  function automatic int unsigned bit_idx(input int unsigned lane,
                                          input int unsigned group,
                                          input int unsigned term,
                                          input int unsigned groups,
                                          input int unsigned term_w);
    return (lane * groups + group) * term_w + term;
  endfunction

endpackage

// File: rtl/gf180mcu_aoi_lane.sv
// Single-lane AND-OR / OR-AND evaluator with optional output inversion.
// Purely combinational; the enclosing pipeline provides all registers.
module gf180mcu_aoi_lane
  import gf180mcu_aoi_pkg::*;
#(
  parameter int GROUPS = 3,
  parameter int TERM_W = 2
) (
  input  logic [GROUPS*TERM_W-1:0] terms_i,
  input  mode_e                    mode_i,
  output logic                     zn_o
);

  logic ao;
  logic oa;

  // Reduce every group, then pick the requested function and polarity.
  always_comb begin
    // NOTE: blocking assignments in combinational logic: each loop pass
    // builds on the partial result left by the previous one.
    ao = 1'b0;
    oa = 1'b1;
    for (int g = 0; g < GROUPS; g++) begin
      ao = ao | (&terms_i[g*TERM_W +: TERM_W]);
      oa = oa & (|terms_i[g*TERM_W +: TERM_W]);
    end
    // NOTE: give every output a value before the case so no path can
    // leave it unassigned and infer a latch.
    zn_o = ~ao;
    case (mode_i)
      MODE_AOI: zn_o = ~ao;
      MODE_OAI: zn_o = ~oa;
      MODE_AO:  zn_o = ao;
      MODE_OA:  zn_o = oa;
      default:  zn_o = ~ao;
    endcase
  end

endmodule

// File: rtl/gf180mcu_aoi_array_pipe.sv
// Two-stage valid/ready pipeline around LANES AND-OR(-INVERT) evaluators.
// Stage 1 captures IN_DATA/MODE, stage 2 holds the lane results on ZN.
// Optional per-lane ZN toggle counters are built when the macro
// GF180MCU_AOI_TOGGLE_CNT_EN is defined; otherwise TOGGLE_CNT reads 0.
module gf180mcu_aoi_array_pipe
  import gf180mcu_aoi_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int GROUPS = 3,
  parameter int TERM_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  inout  wire                       VDD,
  inout  wire                       VSS,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [LANES*GROUPS*TERM_W-1:0] IN_DATA,
  input  logic [1:0]                MODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LANES-1:0]          ZN,
  input  logic                      CNT_CLR,
  output logic [LANES*CNT_W-1:0]    TOGGLE_CNT
);

  localparam int LW = GROUPS * TERM_W;
  localparam int DW = LANES * LW;

  // Supply pins carry no logic; fold them into a named sink.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  mode_e         s1_mode_q, s1_mode_d;
  logic          s2_valid_q, s2_valid_d;
  logic [LANES-1:0] zn_q, zn_d;
  logic [LANES-1:0] lane_zn;

  logic s2_ready;
  logic accept;
  logic s1_advance;

  // s2 can take a new item when empty or when its item leaves this cycle;
  // an empty s2 fills even under backpressure so bubbles collapse.
  assign s2_ready   = !s2_valid_q || OUT_READY;
  assign IN_READY   = !s1_valid_q || s2_ready;
  assign accept     = IN_VALID && IN_READY;
  assign s1_advance = s1_valid_q && s2_ready;

  assign OUT_VALID = s2_valid_q;
  assign ZN        = zn_q;

  // One evaluator per lane, fed from the stage-1 registers.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int BASE = int'(bit_idx(l, 0, 0, GROUPS, TERM_W));
    gf180mcu_aoi_lane #(
      .GROUPS (GROUPS),
      .TERM_W (TERM_W)
    ) u_lane (
      .terms_i (s1_data_q[BASE +: LW]),
      .mode_i  (s1_mode_q),
      .zn_o    (lane_zn[l])
    );
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    zn_d       = zn_q;
    if (s1_advance) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = IN_DATA;
      s1_mode_d  = mode_e'(MODE);
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) zn_d = lane_zn;
    end
  end

  // Pipeline registers.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: data registers are reset along with the valids so ZN comes up
    // at its defined all-ones value instead of X after reset.
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_AOI;
      s2_valid_q <= 1'b0;
      zn_q       <= '1;
    end else begin
      // NOTE: non-blocking assignments for state so every flop samples
      // the pre-edge values regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      zn_q       <= zn_d;
    end
  end

`ifdef GF180MCU_AOI_TOGGLE_CNT_EN
  logic                        out_fire;
  logic [LANES-1:0]            last_zn_q, last_zn_d;
  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign out_fire   = s2_valid_q && OUT_READY;
  assign TOGGLE_CNT = cnt_q;

  // Count lanes whose delivered ZN differs from the previous delivery;
  // clear wins over an increment in the same cycle.
  always_comb begin
    last_zn_d = last_zn_q;
    cnt_d     = cnt_q;
    if (out_fire) last_zn_d = zn_q;
    for (int l = 0; l < LANES; l++) begin
      if (CNT_CLR) begin
        cnt_d[l] = '0;
      end else if (out_fire && (zn_q[l] != last_zn_q[l]) && (cnt_q[l] != '1)) begin
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      end
    end
  end

  // Toggle-counter registers; the reference starts at the ZN reset value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_zn_q <= '1;
      cnt_q     <= '0;
    end else begin
      last_zn_q <= last_zn_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  wire unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign TOGGLE_CNT     = '0;
`endif

endmodule
